prbs31_gen: RTL



---
 rtl/prbs31_gen_if.sv | 27 ++
 rtl/prbs31_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/prbs31_gen_if.sv
// rtl/prbs31_gen_if.sv - byte stream bundle between the PRBS31 generator and its consumer
//
// Signals:
//   out_valid  generator -> consumer  out_data holds a valid PRBS byte
//   out_ready  consumer -> generator  consumer accepts the current byte this cycle
//   out_data   generator -> consumer  PRBS byte, first-generated bit in bit 7
//
// Modports:
//   master  generator side (drives out_valid/out_data)
//   slave   consumer side (drives out_ready)
interface prbs31_gen_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/prbs31_gen.sv
// rtl/prbs31_gen.sv - PRBS31 (x^31+x^28+1) byte generator with valid/ready output
//
// Ports:
//   clk        rising-edge clock, sole clock
//   rst        synchronous active-high reset
//   en         run request, level-sensitive
//   seed_load  single-cycle pulse: load seed, clear beat_cnt, enter SEED
//   seed       31-bit seed sampled with seed_load (0 is replaced by all ones)
//   err_inj    error-injection request pulse (only acts when PRBS31_ERR_INJECT_EN is defined)
//   beat_cnt   count of accepted bytes since reset / seed load, wraps at 16 bits
//   stream     prbs31_gen_if.master: out_valid / out_ready / out_data
//
// Build option:
//   PRBS31_ERR_INJECT_EN  when defined, an err_inj pulse inverts bit 0 of the next
//                         byte loaded for presentation; LFSR state is never touched.
module prbs31_gen (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 seed_load,
    input  logic [30:0]          seed,
    input  logic                 err_inj,
    output logic [15:0]          beat_cnt,
    prbs31_gen_if.master         stream
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [30:0] DEFAULT_SEED = 31'h7FFF_FFFF;

    state_t      state_q, state_d;
    logic [30:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;

    logic [30:0] lfsr_adv;
    logic [30:0] seed_eff;
    logic        handshake;
    logic        byte_load;
    logic        inj_arm;

    // Eight LFSR steps: b = S[30]^S[27], S <= {S[29:0], b}.
    function automatic logic [30:0] lfsr_step8(input logic [30:0] s);
        logic [30:0] t;
        t = s;
        for (int k = 0; k < 8; k++) begin
            t = {t[29:0], t[30] ^ t[27]};
        end
        return t;
    endfunction

    // Byte produced by the next eight steps from s; the first bit lands in bit 7.
    function automatic logic [7:0] lfsr_byte(input logic [30:0] s);
        logic [30:0] t;
        logic [7:0]  b;
        t = s;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            b[7-k] = t[30] ^ t[27];
            t      = {t[29:0], t[30] ^ t[27]};
        end
        return b;
    endfunction

    assign handshake = (state_q == ST_RUN) && stream.out_ready;
    assign lfsr_adv  = lfsr_step8(lfsr_q);
    // An all-zero LFSR never leaves zero, so a zero seed is swapped for all ones.
    assign seed_eff  = (seed == 31'd0) ? DEFAULT_SEED : seed;

`ifdef PRBS31_ERR_INJECT_EN
    logic inj_q, inj_d;

    // The flag and a same-cycle pulse both apply to the byte being loaded now;
    // repeated pulses while armed collapse into the single flag bit.
    assign inj_arm = inj_q | err_inj;

    always_comb begin
        inj_d = inj_arm;
        if (byte_load) begin
            inj_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`else
    logic unused_err_inj;

    assign unused_err_inj = err_inj;
    assign inj_arm        = 1'b0;
`endif

    // Next-state logic. out_data is registered and loaded whenever a new byte is
    // about to be presented, so it stays stable through any stall.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        byte_load = 1'b0;

        if (seed_load) begin
            // Seed load wins over handshake and en, and drops any pending byte.
            state_d = ST_SEED;
            lfsr_d  = seed_eff;
            cnt_d   = 16'd0;
            data_d  = 8'h00;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_SEED: begin
                    if (en) begin
                        state_d   = ST_RUN;
                        data_d    = lfsr_byte(lfsr_q) ^ {7'd0, inj_arm};
                        byte_load = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        lfsr_d = lfsr_adv;
                        cnt_d  = cnt_q + 16'd1;
                        // en is only honoured at a byte boundary.
                        if (en) begin
                            data_d    = lfsr_byte(lfsr_adv) ^ {7'd0, inj_arm};
                            byte_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            data_d  = 8'h00;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= 16'd0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign stream.out_valid = (state_q == ST_RUN);
    assign stream.out_data  = data_q;
    assign beat_cnt         = cnt_q;

endmodule
